// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// requester identifiers and the default memory depth.
package mem_arbiter_pkg;

  localparam int DEPTH_DEFAULT = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin chooser. A lone requester always wins; on a tie the
// input granted most recently loses. Reset leaves index 0 (cpu) favoured.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // last_one: 1 when index 1 won the most recent accepted grant
  logic last_one;

  // Combinational choice from the current requests and history
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last_one ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Remember who won whenever the caller actually takes a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      last_one <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_one <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one synchronous memory port (port A) between a CPU and a
// debug/program loader. One transaction in flight: IDLE/DONE accept, ISSUE
// drives the memory, DONE returns the response.
// Build option: define MEM_ARBITER_DBG_EN to arbitrate the dbg port
// round-robin against cpu; without it the dbg port is inert and cpu is
// granted whenever it requests.
//
// Handshake: *_req is a level request. *_gnt is asserted combinationally in
// the cycle the request is accepted; *_we/*_addr/*_wdata are sampled at the
// rising edge closing that cycle. Exactly one response follows: *_rvalid is
// high for the single DONE cycle two cycles after *_gnt, carrying *_rdata
// (0 for writes and errors) and *_err. Dropping *_req after *_gnt does not
// cancel the accepted transaction; dropping it before gnt loses nothing.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic        dbg_err,
  output logic [31:0] dbg_rdata,
  output logic        wen_A,
  output logic        ren_A,
  output logic [31:0] addr_A,
  output logic [31:0] wdata_A,
  input  logic [31:0] rdata_A,
  output state_t      fsm_state
);

  state_t      state_q;
  req_id_t     owner_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        cpu_rvalid_q, cpu_err_q;
  logic [31:0] cpu_rdata_q;
  logic        dbg_rvalid_q, dbg_err_q;
  logic [31:0] dbg_rdata_q;

  logic        arb_ok;
  logic        win_cpu, win_dbg, accept;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [31:0] resp_data;

  // A new request may be accepted only outside ISSUE and never under reset
  assign arb_ok = !rst && (state_q != ISSUE);

`ifdef MEM_ARBITER_DBG_EN
  logic [1:0] rr_gnt;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({dbg_req, cpu_req}),
    .advance (arb_ok),
    .gnt     (rr_gnt)
  );

  assign win_cpu    = arb_ok && rr_gnt[0];
  assign win_dbg    = arb_ok && rr_gnt[1];
  assign dbg_gnt    = win_dbg;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_err    = dbg_err_q;
  assign dbg_rdata  = dbg_rdata_q;
`else
  logic unused_dbg;

  assign win_cpu    = arb_ok && cpu_req;
  assign win_dbg    = 1'b0;
  assign dbg_gnt    = 1'b0;
  assign dbg_rvalid = 1'b0;
  assign dbg_err    = 1'b0;
  assign dbg_rdata  = 32'd0;
  assign unused_dbg = ^{dbg_req, dbg_rvalid_q, dbg_err_q, dbg_rdata_q};
`endif

  assign accept    = win_cpu || win_dbg;
  assign cpu_gnt   = win_cpu;
  assign sel_we    = win_dbg ? dbg_we    : cpu_we;
  assign sel_addr  = win_dbg ? dbg_addr  : cpu_addr;
  assign sel_wdata = win_dbg ? dbg_wdata : cpu_wdata;

  // Memory port A is only enabled in ISSUE for an in-range address, and
  // never while reset is high
  assign addr_A  = addr_q;
  assign wdata_A = wdata_q;
  assign ren_A   = !rst && (state_q == ISSUE) && !we_q && !err_q;
  assign wen_A   = !rst && (state_q == ISSUE) &&  we_q && !err_q;

  // Writes and out-of-range accesses return zero data
  assign resp_data = (we_q || err_q) ? 32'd0 : rdata_A;

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_err    = cpu_err_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign fsm_state  = state_q;

  // Transaction FSM with registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= REQ_CPU;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      dbg_rvalid_q <= 1'b0;
      dbg_err_q    <= 1'b0;
      dbg_rdata_q  <= 32'd0;
    end else begin
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      dbg_err_q    <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q <= ISSUE;
            owner_q <= win_dbg ? REQ_DBG : REQ_CPU;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            err_q   <= (sel_addr >= 32'(DEPTH));
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          state_q <= DONE;
          if (owner_q == REQ_DBG) begin
            dbg_rvalid_q <= 1'b1;
            dbg_err_q    <= err_q;
            dbg_rdata_q  <= resp_data;
          end else begin
            cpu_rvalid_q <= 1'b1;
            cpu_err_q    <= err_q;
            cpu_rdata_q  <= resp_data;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DEPTH = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] dbg_rdata;
  logic        wen_A, ren_A;
  logic [31:0] addr_A, wdata_A;
  logic [31:0] rdata_A;
  state_t      fsm_state;

  mem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .wen_A(wen_A), .ren_A(ren_A), .addr_A(addr_A), .wdata_A(wdata_A), .rdata_A(rdata_A),
    .fsm_state(fsm_state)
  );

  // ---------------- attached memory (environment) ----------------
  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  logic [31:0] mem [DEPTH];
  bit          mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (wen_A && (addr_A < 32'(DEPTH))) begin
      mem[addr_A] <= wdata_A;
    end
  end

  always @(negedge clk) begin
    if (ren_A && (addr_A < 32'(DEPTH))) rdata_A <= mem[addr_A];
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    int          due;
    logic        id;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_rd [2];
  logic        last_dbg = 1'b1;
  int          cyc = 0;
  bit          checking = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One cycle of the reference model: expectations from the rules, then
  // the effect of the closing rising edge.
  task automatic model_cycle();
    bit   in_issue, in_done, arb_ok, win_c, win_d, mem_en;
    txn_t t, n;
    t = (exp_q.size() > 0) ? exp_q[0] : '0;
    in_issue = (exp_q.size() > 0) && (t.due == cyc + 1);
    in_done  = (exp_q.size() > 0) && (t.due == cyc);
    arb_ok   = !rst && !in_issue;
    win_c = 1'b0;
    win_d = 1'b0;
    if (arb_ok) begin
`ifdef MEM_ARBITER_DBG_EN
      if (cpu_req && dbg_req) begin
        win_c = last_dbg;
        win_d = !last_dbg;
      end else begin
        win_c = cpu_req;
        win_d = dbg_req;
      end
`else
      win_c = cpu_req;
`endif
    end
    mem_en = in_issue && !rst && !t.err;

    if (checking) begin
      check("cpu_gnt",    32'(cpu_gnt),    32'(win_c));
      check("dbg_gnt",    32'(dbg_gnt),    32'(win_d));
      check("cpu_rvalid", 32'(cpu_rvalid), 32'(in_done && !t.id));
      check("cpu_err",    32'(cpu_err),    32'(in_done && !t.id && t.err));
      check("dbg_rvalid", 32'(dbg_rvalid), 32'(in_done && t.id));
      check("dbg_err",    32'(dbg_err),    32'(in_done && t.id && t.err));
      check("cpu_rdata",  cpu_rdata, exp_rd[0]);
      check("dbg_rdata",  dbg_rdata, exp_rd[1]);
      check("ren_A",      32'(ren_A), 32'(mem_en && !t.we));
      check("wen_A",      32'(wen_A), 32'(mem_en && t.we));
      check("state", 32'(fsm_state), in_issue ? 32'(ISSUE) : (in_done ? 32'(DONE) : 32'(IDLE)));
      if (mem_en) begin
        check("addr_A", addr_A, t.addr);
        if (t.we) check("wdata_A", wdata_A, t.wdata);
      end
    end

    if (rst) begin
      exp_q.delete();
      last_dbg  = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else begin
      if (in_issue) begin
        if (!t.err && t.we) ref_mem[t.addr] = t.wdata;
        exp_rd[t.id] = (t.err || t.we) ? 32'd0 : ref_mem[t.addr];
      end
      if (in_done) void'(exp_q.pop_front());
      if (win_c || win_d) begin
        n.due   = cyc + 2;
        n.id    = win_d;
        n.we    = win_d ? dbg_we : cpu_we;
        n.addr  = win_d ? dbg_addr : cpu_addr;
        n.wdata = win_d ? dbg_wdata : cpu_wdata;
        n.err   = (n.addr >= 32'(DEPTH));
        exp_q.push_back(n);
        last_dbg = win_d;
      end
    end
    cyc++;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r,
                      input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                      input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    rst = r;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #3;
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'(DEPTH) + 32'($urandom_range(0, 3));
    if (sel == 1) return 32'hFFFF_FFFF;
    if (sel == 2) return 32'($urandom_range(0, DEPTH - 1));
    return 32'($urandom_range(0, 15));
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] old7;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Reset: first cycle outputs are unknown before any edge, so checking
    // starts on the second reset cycle.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checking = 1'b1;
    step(1, 1, 0, 3, 0, 1, 0, 4, 0);
    idle(2);

    // Write then read back the same word
    step(0, 1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 0, 5, 0, 0, 0, 0, 0);
    idle(3);
    check("wr_rd_hold", cpu_rdata, 32'hDEAD_BEEF);

    // Reset during ISSUE of a write abandons it
    old7 = mem[7];
    step(0, 1, 1, 7, 32'h1234, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    check("rst_abort_mem7", mem[7], old7);

    // Out-of-range cpu read
    step(0, 1, 0, 32'(DEPTH), 0, 0, 0, 0, 0);
    idle(3);

`ifdef MEM_ARBITER_DBG_EN
    // Both requesting from reset: alternating grants
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 32'(i), 0, 1, 0, 32'(i + 20), 0);
    idle(3);
    // dbg read past the end
    step(0, 0, 0, 0, 0, 1, 0, 32'(DEPTH), 0);
    idle(3);
    // cpu pulse in DONE of a dbg transaction
    step(0, 0, 0, 0, 0, 1, 0, 9, 0);
    idle(1);
    step(0, 1, 0, 5, 0, 0, 0, 0, 0);
    idle(3);
`else
    // dbg held high is ignored; cpu served normally
    step(0, 1, 0, 0, 0, 1, 0, 3, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1, 3, 32'h55);
    idle(2);
`endif

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom());
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
